// File: rtl/smi_pkg.sv
// Shared SMI definitions for the write-path arbiter: eofc encoding, tag routing field
// and the arbiter state type.
package smi_pkg;

  localparam int unsigned NumPorts          = 4;
  localparam int unsigned PortIdxWidth      = 2;
  localparam int unsigned EofcWidth         = 8;
  localparam int unsigned HdrWidth          = 32;
  localparam int unsigned SMI_TAG_ROUTE_LSB = 30;

  localparam logic [7:0] WRITE_RESP_ID_BYTE = 8'hFE;
  localparam logic [7:0] SMI_EOFC_MID_FRAME = 8'h00;

  typedef enum logic {
    ArbIdle,
    ArbForward
  } arbState_t;

  // Overwrite the requester index field of a header word
  function automatic logic [HdrWidth-1:0] stampRoute(
    input logic [HdrWidth-1:0]     hdr,
    input logic [PortIdxWidth-1:0] route
  );
    logic [HdrWidth-1:0] res;
    res = hdr;
    res[SMI_TAG_ROUTE_LSB +: PortIdxWidth] = route;
    return res;
  endfunction

endpackage

// File: rtl/smi_toggle_buffer.sv
// Single-entry valid/stop register; loads only when empty, so it alternates
// between load and drain cycles.
module smi_toggle_buffer #(
  parameter int unsigned Width = 136
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             inReady,
  input  logic [Width-1:0] inData,
  output logic             inStop,
  output logic             outReady,
  output logic [Width-1:0] outData,
  input  logic             outStop
);

  logic             valid;
  logic [Width-1:0] data;

  always_ff @(posedge clk) begin
    if (srst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (valid) begin
      if (!outStop) valid <= 1'b0;
    end else if (inReady) begin
      valid <= 1'b1;
      data  <= inData;
    end
  end

  assign inStop   = valid;
  assign outReady = valid;
  assign outData  = data;

endmodule

// File: rtl/smi_write_arbiter.sv
// Four-way SMI write arbiter: round-robin, frame-locked request grant with the
// requester index stamped into the tag, and tag-routed write responses.
module smi_write_arbiter
  import smi_pkg::*;
#(
  parameter  int unsigned DataIndexSize = 4,
  localparam int unsigned DataWidth     = (1 << DataIndexSize) * 8
) (
  input  logic                            clk,
  input  logic                            srst,
  input  logic [NumPorts-1:0]             reqInReady,
  input  logic [NumPorts*EofcWidth-1:0]   reqInEofc,
  input  logic [NumPorts*DataWidth-1:0]   reqInData,
  output logic [NumPorts-1:0]             reqInStop,
  output logic                            reqOutReady,
  output logic [EofcWidth-1:0]            reqOutEofc,
  output logic [DataWidth-1:0]            reqOutData,
  input  logic                            reqOutStop,
  input  logic                            respInReady,
  input  logic [EofcWidth-1:0]            respInEofc,
  input  logic [DataWidth-1:0]            respInData,
  output logic                            respInStop,
  output logic [NumPorts-1:0]             respOutReady,
  output logic [EofcWidth-1:0]            respOutEofc,
  output logic [DataWidth-1:0]            respOutData,
  input  logic [NumPorts-1:0]             respOutStop
);

  localparam int unsigned BufWidth = DataWidth + EofcWidth;

  arbState_t               state;
  logic [PortIdxWidth-1:0] grant;
  logic [PortIdxWidth-1:0] lastGrant;
  logic [PortIdxWidth-1:0] rrPick;
  logic                    firstWord;

  logic [DataWidth-1:0]    selData;
  logic [DataWidth-1:0]    stampedData;
  logic [EofcWidth-1:0]    selEofc;
  logic                    selReady;
  logic                    reqLoad;
  logic                    reqBufFull;
  logic                    accept;

  // Lowest offset from lastGrant wins; offset NumPorts wraps back onto lastGrant
  always_comb begin
    rrPick = lastGrant;
    for (int i = NumPorts; i >= 1; i--) begin
      if (reqInReady[lastGrant + PortIdxWidth'(i)]) rrPick = lastGrant + PortIdxWidth'(i);
    end
  end

  always_comb begin
    selData  = '0;
    selEofc  = '0;
    selReady = 1'b0;
    for (int p = 0; p < NumPorts; p++) begin
      if (grant == PortIdxWidth'(p)) begin
        selData  = reqInData[p*DataWidth +: DataWidth];
        selEofc  = reqInEofc[p*EofcWidth +: EofcWidth];
        selReady = reqInReady[p];
      end
    end
  end

  always_comb begin
    stampedData = selData;
    if (firstWord) stampedData[HdrWidth-1:0] = stampRoute(selData[HdrWidth-1:0], grant);
  end

  assign reqLoad = (state == ArbForward) && selReady;
  assign accept  = reqLoad && !reqBufFull;

  always_comb begin
    reqInStop = '1;
    if (state == ArbForward) reqInStop[grant] = reqBufFull;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state     <= ArbIdle;
      grant     <= '0;
      lastGrant <= PortIdxWidth'(NumPorts - 1);
      firstWord <= 1'b0;
    end else begin
      case (state)
        ArbIdle: begin
          if (|reqInReady) begin
            grant     <= rrPick;
            lastGrant <= rrPick;
            firstWord <= 1'b1;
            state     <= ArbForward;
          end
        end
        ArbForward: begin
          if (accept) begin
            firstWord <= 1'b0;
            if (selEofc != SMI_EOFC_MID_FRAME) state <= ArbIdle;
          end
        end
        default: state <= ArbIdle;
      endcase
    end
  end

  logic [BufWidth-1:0] reqOutBus;

  smi_toggle_buffer #(.Width(BufWidth)) reqBuf (
    .clk      (clk),
    .srst     (srst),
    .inReady  (reqLoad),
    .inData   ({selEofc, stampedData}),
    .inStop   (reqBufFull),
    .outReady (reqOutReady),
    .outData  (reqOutBus),
    .outStop  (reqOutStop)
  );

  assign {reqOutEofc, reqOutData} = reqOutBus;

  // Response path: route by the stamped index, then hand the tag back clean
  logic                    respValid;
  logic [BufWidth-1:0]     respBus;
  logic [DataWidth-1:0]    respDataQ;
  logic [PortIdxWidth-1:0] route;

  smi_toggle_buffer #(.Width(BufWidth)) respBuf (
    .clk      (clk),
    .srst     (srst),
    .inReady  (respInReady),
    .inData   ({respInEofc, respInData}),
    .inStop   (respInStop),
    .outReady (respValid),
    .outData  (respBus),
    .outStop  (respOutStop[route])
  );

  assign {respOutEofc, respDataQ} = respBus;
  assign route        = respDataQ[SMI_TAG_ROUTE_LSB +: PortIdxWidth];
  assign respOutReady = respValid ? (NumPorts'(1) << route) : '0;

  always_comb begin
    respOutData = respDataQ;
    respOutData[HdrWidth-1:0] = stampRoute(respDataQ[HdrWidth-1:0], '0);
  end

endmodule

// File: tb/tb_smi_write_arbiter.sv
// Randomised bench for smi_write_arbiter against a frame-level round-robin and
// response-routing model, plus directed cases with literal expectations.
module tb_smi_write_arbiter;
  import smi_pkg::*;

  localparam int DW = 128;

  typedef struct { logic [DW-1:0] d; logic [7:0] e; } word_t;
  typedef struct { logic [DW-1:0] d; logic [7:0] e; int port; } exp_t;

  logic            clk = 1'b0;
  logic            srst;
  logic [3:0]      reqInReady;
  logic [31:0]     reqInEofc;
  logic [4*DW-1:0] reqInData;
  logic [3:0]      reqInStop;
  logic            reqOutReady;
  logic [7:0]      reqOutEofc;
  logic [DW-1:0]   reqOutData;
  logic            reqOutStop;
  logic            respInReady;
  logic [7:0]      respInEofc;
  logic [DW-1:0]   respInData;
  logic            respInStop;
  logic [3:0]      respOutReady;
  logic [7:0]      respOutEofc;
  logic [DW-1:0]   respOutData;
  logic [3:0]      respOutStop;

  always #5 clk = ~clk;

  smi_write_arbiter #(.DataIndexSize(4)) dut (
    .clk(clk), .srst(srst),
    .reqInReady(reqInReady), .reqInEofc(reqInEofc), .reqInData(reqInData), .reqInStop(reqInStop),
    .reqOutReady(reqOutReady), .reqOutEofc(reqOutEofc), .reqOutData(reqOutData), .reqOutStop(reqOutStop),
    .respInReady(respInReady), .respInEofc(respInEofc), .respInData(respInData), .respInStop(respInStop),
    .respOutReady(respOutReady), .respOutEofc(respOutEofc), .respOutData(respOutData), .respOutStop(respOutStop)
  );

  word_t portQ[4][$];
  word_t respSrc[$];
  exp_t  expQ[$];
  exp_t  respQ[$];
  word_t outLog[$];
  logic [3:0]    respRdyLog[$];
  logic [DW-1:0] respDataLog[$];

  int errors = 0;
  int checks = 0;
  int modelLast = 3;
  int respGenLeft = 0;
  logic reqStopRand = 1'b0, reqStopForce = 1'b0;
  logic respStopRand = 1'b0;
  logic [3:0] respStopForce = 4'h0;
  logic prevHold = 1'b0;
  logic [135:0] prevWord = '0;

  function automatic logic [DW-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic addFrame(input int p, input int len, input logic [DW-1:0] hdr, input logic [7:0] lastE);
    word_t w;
    for (int i = 0; i < len; i++) begin
      w.d = (i == 0) ? hdr : rand128();
      w.e = (i == len - 1) ? lastE : 8'h00;
      portQ[p].push_back(w);
    end
  endtask

  // Model: whole frames leave in round-robin order over ports with pending frames
  task automatic buildExpected();
    word_t cp[4][$];
    word_t w;
    exp_t  e;
    int    pick;
    bit    first;
    for (int p = 0; p < 4; p++) cp[p] = portQ[p];
    forever begin
      pick = -1;
      for (int k = 1; k <= 4 && pick < 0; k++)
        if (cp[(modelLast + k) % 4].size() > 0) pick = (modelLast + k) % 4;
      if (pick < 0) break;
      first = 1'b1;
      do begin
        w = cp[pick].pop_front();
        e.d = w.d;
        if (first) e.d[31:30] = 2'(pick);
        first = 1'b0;
        e.e = w.e;
        e.port = pick;
        expQ.push_back(e);
      end while (w.e == 8'h00 && cp[pick].size() > 0);
      modelLast = pick;
    end
  endtask

  task automatic drive();
    word_t w;
    for (int p = 0; p < 4; p++) begin
      if (portQ[p].size() > 0) begin
        reqInReady[p] = 1'b1;
        reqInData[p*DW +: DW] = portQ[p][0].d;
        reqInEofc[p*8 +: 8] = portQ[p][0].e;
      end else begin
        reqInReady[p] = 1'b0;
        reqInData[p*DW +: DW] = rand128();
        reqInEofc[p*8 +: 8] = 8'($urandom);
      end
    end
    reqOutStop  = reqStopRand ? ($urandom_range(0, 2) == 0) : reqStopForce;
    respOutStop = respStopRand ? 4'($urandom) : respStopForce;
    if (respGenLeft > 0 && respSrc.size() == 0 && $urandom_range(0, 1) == 1) begin
      w.d = rand128();
      w.e = 8'($urandom_range(1, 255));
      respSrc.push_back(w);
      respGenLeft--;
    end
    if (respSrc.size() > 0) begin
      respInReady = 1'b1;
      respInData  = respSrc[0].d;
      respInEofc  = respSrc[0].e;
    end else begin
      respInReady = 1'b0;
      respInData  = rand128();
      respInEofc  = 8'h00;
    end
  endtask

  // One clock: compare at negedge, advance, redrive just after posedge
  task automatic cycle();
    exp_t e;
    int   zeros;
    @(negedge clk);
    if (srst) begin
      prevHold = 1'b0;
    end else begin
      if (prevHold) begin
        check("req_hold_valid", reqOutReady, 1'b1);
        check("req_hold_word", {reqOutEofc, reqOutData}, prevWord);
      end
      if (reqOutReady) check("req_in_stop_full", reqInStop, 4'hF);
      zeros = 0;
      for (int p = 0; p < 4; p++) begin
        if (!reqInStop[p]) begin
          zeros++;
          if (expQ.size() == 0) check("req_grant_unexpected", 1, 0);
          else check("req_grant_port", p, expQ[0].port);
        end
      end
      check("req_in_stop_single", zeros <= 1, 1'b1);
      if (reqOutReady && !reqOutStop) begin
        if (expQ.size() == 0) check("req_out_unexpected", {reqOutEofc, reqOutData}, 0);
        else begin
          e = expQ.pop_front();
          check("req_out_word", {reqOutEofc, reqOutData}, {e.e, e.d});
        end
        outLog.push_back('{d: reqOutData, e: reqOutEofc});
      end
      prevHold = reqOutReady && reqOutStop;
      prevWord = {reqOutEofc, reqOutData};
      for (int p = 0; p < 4; p++)
        if (reqInReady[p] && !reqInStop[p] && portQ[p].size() > 0) void'(portQ[p].pop_front());

      check("resp_in_stop", respInStop, respOutReady != 4'h0);
      if (respOutReady != 4'h0) begin
        respRdyLog.push_back(respOutReady);
        respDataLog.push_back(respOutData);
        if (respQ.size() == 0) check("resp_out_unexpected", respOutReady, 0);
        else begin
          check("resp_out_ready", respOutReady, 4'(1) << respQ[0].port);
          check("resp_out_word", {respOutEofc, respOutData}, {respQ[0].e, respQ[0].d});
          if ((respOutReady & ~respOutStop) != 4'h0) void'(respQ.pop_front());
        end
      end
      if (respInReady && !respInStop) begin
        e.port = int'(respInData[31:30]);
        e.d = respInData;
        e.d[31:30] = 2'b00;
        e.e = respInEofc;
        respQ.push_back(e);
        if (respSrc.size() > 0) void'(respSrc.pop_front());
      end
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  function automatic bit drained();
    for (int p = 0; p < 4; p++) if (portQ[p].size() > 0) return 1'b0;
    return expQ.size() == 0 && respQ.size() == 0 && respSrc.size() == 0 && respGenLeft == 0;
  endfunction

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (!drained() && n < budget) begin
      cycle();
      n++;
    end
    if (!drained()) check({name, "_timeout"}, 1, 0);
  endtask

  task automatic waitOut(input int cnt, input int budget);
    int n = 0;
    while (outLog.size() < cnt && n < budget) begin
      cycle();
      n++;
    end
    if (outLog.size() < cnt) check("wait_out_timeout", outLog.size(), cnt);
  endtask

  task automatic startPhase();
    outLog.delete();
    respRdyLog.delete();
    respDataLog.delete();
    buildExpected();
    drive();
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_reqOutReady"}, reqOutReady, 1'b0);
    check({tag, "_respOutReady"}, respOutReady, 4'h0);
    check({tag, "_reqInStop"}, reqInStop, 4'hF);
    check({tag, "_respInStop"}, respInStop, 1'b0);
  endtask

  task automatic doReset(input string tag);
    srst = 1'b1;
    for (int p = 0; p < 4; p++) portQ[p].delete();
    expQ.delete();
    respQ.delete();
    respSrc.delete();
    respGenLeft = 0;
    drive();
    repeat (2) cycle();
    checkReset(tag);
    srst = 1'b0;
    modelLast = 3;
  endtask

  initial begin
    logic [DW-1:0] hdr;
    word_t w;
    srst = 1'b1;
    reqInReady = '0; reqInEofc = '0; reqInData = '0; reqOutStop = 1'b0;
    respInReady = 1'b0; respInEofc = '0; respInData = '0; respOutStop = '0;
    repeat (3) cycle();
    checkReset("reset");
    srst = 1'b0;

    // Port 2, three-word frame, tag 0x0012
    hdr = rand128();
    hdr[31:16] = 16'h0012;
    addFrame(2, 3, hdr, 8'h04);
    startPhase();
    drain("single", 200);
    check("single_count", outLog.size(), 3);
    if (outLog.size() == 3) begin
      check("single_tag", outLog[0].d[31:16], 16'h8012);
      check("single_eofc_mid", outLog[1].e, 8'h00);
      check("single_eofc_last", outLog[2].e, 8'h04);
    end
    repeat (2) cycle();
    check("single_idle_stop", reqInStop, 4'hF);

    // All ports busy from reset: grant order 0,1,2,3,0
    doReset("reset2");
    for (int p = 0; p < 4; p++) addFrame(p, 2, rand128(), 8'h10);
    addFrame(0, 2, rand128(), 8'h10);
    startPhase();
    drain("rr", 300);
    check("rr_count", outLog.size(), 10);
    if (outLog.size() == 10) begin
      check("rr_order0", outLog[0].d[31:30], 2'd0);
      check("rr_order1", outLog[2].d[31:30], 2'd1);
      check("rr_order2", outLog[4].d[31:30], 2'd2);
      check("rr_order3", outLog[6].d[31:30], 2'd3);
      check("rr_order4", outLog[8].d[31:30], 2'd0);
    end

    // Downstream stall for 5 cycles mid-frame
    addFrame(1, 4, rand128(), 8'h08);
    startPhase();
    waitOut(1, 50);
    reqStopForce = 1'b1;
    drive();
    repeat (5) cycle();
    check("stall_held_count", outLog.size(), 1);
    reqStopForce = 1'b0;
    drive();
    drain("stall", 100);
    check("stall_count", outLog.size(), 4);

    // Response routed to port 1 with tag cleared
    startPhase();
    w.d = rand128();
    w.d[31:0] = {16'h4012, 8'h00, WRITE_RESP_ID_BYTE};
    w.e = 8'h10;
    respSrc.push_back(w);
    drive();
    drain("resp1", 50);
    check("resp1_count", respRdyLog.size(), 1);
    if (respRdyLog.size() > 0) begin
      check("resp1_ready", respRdyLog[0], 4'b0010);
      check("resp1_data", respDataLog[0][31:0], 32'h001200FE);
    end

    // Response to port 3 stalled four cycles
    startPhase();
    respStopForce = 4'b1000;
    w.d = rand128();
    w.d[31:30] = 2'd3;
    respSrc.push_back(w);
    drive();
    repeat (5) cycle();
    check("resp3_stall_logs", respRdyLog.size(), 4);
    check("resp3_pending", respQ.size(), 1);
    respStopForce = 4'b0000;
    drive();
    drain("resp3", 50);
    check("resp3_total_logs", respRdyLog.size(), 5);
    if (respRdyLog.size() > 0) check("resp3_ready", respRdyLog[0], 4'b1000);

    // Reset mid-frame on port 1, then ports 1 and 0 compete
    addFrame(1, 4, rand128(), 8'h02);
    startPhase();
    waitOut(2, 50);
    doReset("midreset");
    addFrame(1, 1, rand128(), 8'h01);
    addFrame(0, 1, rand128(), 8'h01);
    startPhase();
    drain("postreset", 100);
    check("postreset_count", outLog.size(), 2);
    if (outLog.size() == 2) begin
      check("postreset_first", outLog[0].d[31:30], 2'd0);
      check("postreset_second", outLog[1].d[31:30], 2'd1);
    end

    // Randomised traffic with random backpressure on both paths
    reqStopRand = 1'b1;
    respStopRand = 1'b1;
    for (int r = 0; r < 8; r++) begin
      for (int p = 0; p < 4; p++) begin
        int nf = $urandom_range(0, 3);
        for (int f = 0; f < nf; f++)
          addFrame(p, $urandom_range(1, 4), rand128(), 8'($urandom_range(1, 255)));
      end
      respGenLeft = 12;
      startPhase();
      drain("random", 4000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
